// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: picks forwarded operands in decode and registers them with decoded control into EX.
// 1-cycle latency; a Stall or Flush loads a zeroed bubble, with saturating stall/flush event counters.
module id_ex_stage #(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Stall,
  input  logic             Flush,
  input  logic [1:0]       ForwardA,
  input  logic [1:0]       ForwardB,
  input  logic [W-1:0]     RegA_ID,
  input  logic [W-1:0]     RegB_ID,
  input  logic [W-1:0]     ALUResult_EX,
  input  logic [W-1:0]     Result_MEM,
  input  logic [W-1:0]     Result_WB,
  input  logic [W-1:0]     Imm_ID,
  input  logic [W-1:0]     PC_ID,
  input  logic [4:0]       Rd_ID,
  input  logic             RegWrite_ID,
  input  logic             MemRead_ID,
  input  logic             MemWrite_ID,
  input  logic             ALUSrc_ID,
  input  logic             RPzero_ID,
  input  logic [3:0]       ALUOp_ID,
  input  logic [1:0]       WBSel_ID,
  output logic [W-1:0]     OpA_EX,
  output logic [W-1:0]     OpB_EX,
  output logic [W-1:0]     Imm_EX,
  output logic [W-1:0]     PC_EX,
  output logic [4:0]       Rd_EX,
  output logic             RegWrite_EX,
  output logic             MemRead_EX,
  output logic             MemWrite_EX,
  output logic             ALUSrc_EX,
  output logic             RPzero_EX,
  output logic [3:0]       ALUOp_EX,
  output logic [1:0]       WBSel_EX,
  output logic             Valid_EX,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  logic [W-1:0]     op_a_next, op_b_next;
  logic [W-1:0]     op_a_d, op_b_d, imm_d, pc_d;
  logic [W-1:0]     op_a_q, op_b_q, imm_q, pc_q;
  logic [4:0]       rd_d, rd_q;
  logic             reg_write_d, mem_read_d, mem_write_d, alu_src_d, rpzero_d, valid_d;
  logic             reg_write_q, mem_read_q, mem_write_q, alu_src_q, rpzero_q, valid_q;
  logic [3:0]       alu_op_d, alu_op_q;
  logic [1:0]       wb_sel_d, wb_sel_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;
  logic             bubble;

  always_comb begin
    op_a_next = RegA_ID;
    case (ForwardA)
      2'b00: op_a_next = RegA_ID;
      2'b01: op_a_next = ALUResult_EX;
      2'b10: op_a_next = Result_MEM;
      2'b11: op_a_next = Result_WB;
    endcase
  end

  always_comb begin
    op_b_next = RegB_ID;
    case (ForwardB)
      2'b00: op_b_next = RegB_ID;
      2'b01: op_b_next = ALUResult_EX;
      2'b10: op_b_next = Result_MEM;
      2'b11: op_b_next = Result_WB;
    endcase
  end

  assign bubble = Flush | Stall;

  // A bubble clears every field so nothing downstream can match it for forwarding or load-use.
  always_comb begin
    op_a_d      = '0;
    op_b_d      = '0;
    imm_d       = '0;
    pc_d        = '0;
    rd_d        = '0;
    reg_write_d = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    alu_src_d   = 1'b0;
    rpzero_d    = 1'b0;
    alu_op_d    = '0;
    wb_sel_d    = '0;
    valid_d     = 1'b0;
    if (!bubble) begin
      op_a_d      = op_a_next;
      op_b_d      = op_b_next;
      imm_d       = Imm_ID;
      pc_d        = PC_ID;
      rd_d        = Rd_ID;
      reg_write_d = RegWrite_ID;
      mem_read_d  = MemRead_ID;
      mem_write_d = MemWrite_ID;
      alu_src_d   = ALUSrc_ID;
      rpzero_d    = RPzero_ID;
      alu_op_d    = ALUOp_ID;
      wb_sel_d    = WBSel_ID;
      valid_d     = 1'b1;
    end
  end

  // Flush wins over Stall, so a combined event is counted only as a flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (Flush) begin
      if (flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + 1'b1;
    end else if (Stall) begin
      if (stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q      <= '0;
      op_b_q      <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      alu_src_q   <= 1'b0;
      rpzero_q    <= 1'b0;
      alu_op_q    <= '0;
      wb_sel_q    <= '0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      alu_src_q   <= alu_src_d;
      rpzero_q    <= rpzero_d;
      alu_op_q    <= alu_op_d;
      wb_sel_q    <= wb_sel_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign OpA_EX      = op_a_q;
  assign OpB_EX      = op_b_q;
  assign Imm_EX      = imm_q;
  assign PC_EX       = pc_q;
  assign Rd_EX       = rd_q;
  assign RegWrite_EX = reg_write_q;
  assign MemRead_EX  = mem_read_q;
  assign MemWrite_EX = mem_write_q;
  assign ALUSrc_EX   = alu_src_q;
  assign RPzero_EX   = rpzero_q;
  assign ALUOp_EX    = alu_op_q;
  assign WBSel_EX    = wb_sel_q;
  assign Valid_EX    = valid_q;
  assign StallCount  = stall_cnt_q;
  assign FlushCount  = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios then random traffic against a cycle-level reference model.
module tb_id_ex_stage;
  localparam int W     = 32;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst, Stall, Flush;
  logic [1:0] ForwardA, ForwardB;
  logic [W-1:0] RegA_ID, RegB_ID, ALUResult_EX, Result_MEM, Result_WB, Imm_ID, PC_ID;
  logic [4:0] Rd_ID;
  logic RegWrite_ID, MemRead_ID, MemWrite_ID, ALUSrc_ID, RPzero_ID;
  logic [3:0] ALUOp_ID;
  logic [1:0] WBSel_ID;
  logic [W-1:0] OpA_EX, OpB_EX, Imm_EX, PC_EX;
  logic [4:0] Rd_EX;
  logic RegWrite_EX, MemRead_EX, MemWrite_EX, ALUSrc_EX, RPzero_EX;
  logic [3:0] ALUOp_EX;
  logic [1:0] WBSel_EX;
  logic Valid_EX;
  logic [CNT_W-1:0] StallCount, FlushCount;

  int checks = 0;
  int errors = 0;

  // Reference model state: what EX should hold after the next edge.
  logic [W-1:0] e_opa, e_opb, e_imm, e_pc;
  logic [4:0] e_rd;
  logic e_rw, e_mr, e_mw, e_as, e_rp, e_v;
  logic [3:0] e_op;
  logic [1:0] e_wb;
  int e_sc, e_fc;

  always #5 clk = ~clk;

  id_ex_stage #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush),
    .ForwardA(ForwardA), .ForwardB(ForwardB),
    .RegA_ID(RegA_ID), .RegB_ID(RegB_ID), .ALUResult_EX(ALUResult_EX),
    .Result_MEM(Result_MEM), .Result_WB(Result_WB), .Imm_ID(Imm_ID), .PC_ID(PC_ID),
    .Rd_ID(Rd_ID), .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID),
    .MemWrite_ID(MemWrite_ID), .ALUSrc_ID(ALUSrc_ID), .RPzero_ID(RPzero_ID),
    .ALUOp_ID(ALUOp_ID), .WBSel_ID(WBSel_ID),
    .OpA_EX(OpA_EX), .OpB_EX(OpB_EX), .Imm_EX(Imm_EX), .PC_EX(PC_EX), .Rd_EX(Rd_EX),
    .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
    .ALUSrc_EX(ALUSrc_EX), .RPzero_EX(RPzero_EX), .ALUOp_EX(ALUOp_EX),
    .WBSel_EX(WBSel_EX), .Valid_EX(Valid_EX), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_fields();
    RegA_ID = $urandom; RegB_ID = $urandom; ALUResult_EX = $urandom;
    Result_MEM = $urandom; Result_WB = $urandom; Imm_ID = $urandom; PC_ID = $urandom;
    Rd_ID = 5'($urandom); ALUOp_ID = 4'($urandom); WBSel_ID = 2'($urandom);
    ForwardA = 2'($urandom); ForwardB = 2'($urandom);
    RegWrite_ID = 1'($urandom); MemRead_ID = 1'($urandom); MemWrite_ID = 1'($urandom);
    ALUSrc_ID = 1'($urandom); RPzero_ID = 1'($urandom);
  endtask

  // Expected EX contents from the current ID inputs, by priority rst > Flush > Stall > load.
  task automatic model();
    logic [W-1:0] src [4];
    src[0] = RegA_ID; src[1] = ALUResult_EX; src[2] = Result_MEM; src[3] = Result_WB;
    if (rst) begin
      {e_opa, e_opb, e_imm, e_pc, e_rd, e_rw, e_mr, e_mw, e_as, e_rp, e_op, e_wb, e_v} = '0;
      e_sc = 0; e_fc = 0;
    end else if (Flush || Stall) begin
      {e_opa, e_opb, e_imm, e_pc, e_rd, e_rw, e_mr, e_mw, e_as, e_rp, e_op, e_wb, e_v} = '0;
      if (Flush) e_fc = (e_fc < MAXC) ? e_fc + 1 : MAXC;
      else       e_sc = (e_sc < MAXC) ? e_sc + 1 : MAXC;
    end else begin
      e_opa = src[ForwardA];
      src[0] = RegB_ID;
      e_opb = src[ForwardB];
      e_imm = Imm_ID; e_pc = PC_ID; e_rd = Rd_ID;
      e_rw = RegWrite_ID; e_mr = MemRead_ID; e_mw = MemWrite_ID;
      e_as = ALUSrc_ID; e_rp = RPzero_ID; e_op = ALUOp_ID; e_wb = WBSel_ID; e_v = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("OpA_EX", 64'(OpA_EX), 64'(e_opa));
    chk("OpB_EX", 64'(OpB_EX), 64'(e_opb));
    chk("Imm_EX", 64'(Imm_EX), 64'(e_imm));
    chk("PC_EX", 64'(PC_EX), 64'(e_pc));
    chk("Rd_EX", 64'(Rd_EX), 64'(e_rd));
    chk("ctrl_EX", 64'({RegWrite_EX, MemRead_EX, MemWrite_EX, ALUSrc_EX, RPzero_EX}),
        64'({e_rw, e_mr, e_mw, e_as, e_rp}));
    chk("ALUOp_EX", 64'(ALUOp_EX), 64'(e_op));
    chk("WBSel_EX", 64'(WBSel_EX), 64'(e_wb));
    chk("Valid_EX", 64'(Valid_EX), 64'(e_v));
    chk("StallCount", 64'(StallCount), 64'(e_sc));
    chk("FlushCount", 64'(FlushCount), 64'(e_fc));
  endtask

  task automatic step();
    model();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic quiet_load();
    rand_fields();
    rst = 1'b0; Stall = 1'b0; Flush = 1'b0;
  endtask

  initial begin
    e_sc = 0; e_fc = 0;
    // Reset held two cycles with busy inputs.
    rand_fields();
    RegA_ID = 32'hdead_beef; RegWrite_ID = 1'b1;
    rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
    step();
    step();
    chk("rst_valid", 64'(Valid_EX), 64'(0));
    chk("rst_opa", 64'(OpA_EX), 64'(0));

    // First load after reset.
    quiet_load();
    RegA_ID = 32'h11; ForwardA = 2'b00; RegWrite_ID = 1'b1;
    step();
    chk("post_rst_opa", 64'(OpA_EX), 64'h11);
    chk("post_rst_rw", 64'(RegWrite_EX), 64'(1));
    chk("post_rst_valid", 64'(Valid_EX), 64'(1));

    // Forward sweep on A, then on B with A held at regfile.
    for (int s = 0; s < 4; s++) begin
      quiet_load();
      RegA_ID = 32'h1; ALUResult_EX = 32'h2; Result_MEM = 32'h3; Result_WB = 32'h4;
      ForwardA = 2'(s); ForwardB = 2'b00; RegB_ID = 32'h99;
      step();
      chk("fwdA_sweep", 64'(OpA_EX), 64'(s + 1));
    end
    for (int s = 0; s < 4; s++) begin
      quiet_load();
      RegA_ID = 32'h1; RegB_ID = 32'h1; ALUResult_EX = 32'h2; Result_MEM = 32'h3; Result_WB = 32'h4;
      ForwardA = 2'b00; ForwardB = 2'(s);
      step();
      chk("fwdB_sweep", 64'(OpB_EX), 64'(s + 1));
      chk("fwdB_no_xtalk", 64'(OpA_EX), 64'h1);
    end

    // Load-use stall then reload of the same instruction.
    quiet_load();
    MemRead_ID = 1'b1; RegWrite_ID = 1'b1; Rd_ID = 5'd5; Stall = 1'b1;
    step();
    chk("stall_rd", 64'(Rd_EX), 64'(0));
    chk("stall_ctrl", 64'({RegWrite_EX, MemRead_EX, Valid_EX}), 64'(0));
    chk("stall_cnt", 64'(StallCount), 64'(1));
    Stall = 1'b0;
    step();
    chk("reload_rd", 64'(Rd_EX), 64'(5));
    chk("reload_mr", 64'(MemRead_EX), 64'(1));

    // Flush and Stall together: one bubble counted as a flush only.
    quiet_load();
    Flush = 1'b1; Stall = 1'b1;
    step();
    chk("flush_stall_fc", 64'(FlushCount), 64'(1));
    chk("flush_stall_sc", 64'(StallCount), 64'(1));
    chk("flush_stall_valid", 64'(Valid_EX), 64'(0));

    // Saturation of the stall counter, then reset clears it.
    for (int i = 0; i < 20; i++) begin
      quiet_load();
      Stall = 1'b1;
      step();
    end
    chk("stall_sat", 64'(StallCount), 64'(MAXC));
    quiet_load();
    rst = 1'b1;
    step();
    chk("sat_rst", 64'(StallCount), 64'(0));

    // Reset in the middle of a burst of valid loads.
    for (int i = 0; i < 3; i++) begin
      quiet_load();
      step();
    end
    quiet_load();
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 64'(Valid_EX), 64'(0));
    chk("mid_rst_pc", 64'(PC_EX), 64'(0));
    quiet_load();
    RegA_ID = 32'h11; ForwardA = 2'b00; RegWrite_ID = 1'b1;
    step();
    chk("mid_rst_reload", 64'({OpA_EX, RegWrite_EX, Valid_EX}), 64'({32'h11, 1'b1, 1'b1}));

    // Random traffic including occasional resets and saturation of the flush counter.
    for (int i = 0; i < 400; i++) begin
      rand_fields();
      rst   = ($urandom_range(0, 49) == 0);
      Flush = ($urandom_range(0, 5) == 0);
      Stall = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the predicated 5-stage core.
- Uses the hazard unit's ForwardA/ForwardB selects to choose the final source operands in decode, then registers them with the decoded control into EX.
- Inserts a bubble on a load-use Stall and squashes on Flush (taken branch/jump).
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- W, 32, datapath width (operands, immediate, PC).
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- Stall  input  1  load-use stall from the hazard unit
- Flush  input  1  squash the instruction leaving ID
- ForwardA  input  2  Rs operand select: 00 regfile, 01 EX, 10 MEM, 11 WB
- ForwardB  input  2  Rt operand select, same encoding
- RegA_ID  input  W  register-file read data, Rs
- RegB_ID  input  W  register-file read data, Rt
- ALUResult_EX  input  W  forward source for select 01
- Result_MEM  input  W  forward source for select 10
- Result_WB  input  W  forward source for select 11
- Imm_ID  input  W  extended immediate
- PC_ID  input  W  PC of the ID instruction
- Rd_ID  input  5  destination register
- RegWrite_ID, MemRead_ID, MemWrite_ID, ALUSrc_ID, RPzero_ID  input  1 each  decoded control
- ALUOp_ID  input  4  ALU operation
- WBSel_ID  input  2  writeback source select
- OpA_EX, OpB_EX, Imm_EX, PC_EX  output  W each  registered values
- Rd_EX  output  5  registered destination register
- RegWrite_EX, MemRead_EX, MemWrite_EX, ALUSrc_EX, RPzero_EX  output  1 each  registered control
- ALUOp_EX  output  4  registered ALU operation
- WBSel_EX  output  2  registered writeback select
- Valid_EX  output  1  1 = real instruction in EX, 0 = bubble
- StallCount  output  CNT_W  cycles on which Stall was honoured
- FlushCount  output  CNT_W  cycles on which Flush was asserted

Behaviour:
- All outputs are registered on the rising edge of clk. Latency from ID to EX is 1 cycle.
- Operand select (combinational, before the register):
  - OpA_next = mux4(RegA_ID, ALUResult_EX, Result_MEM, Result_WB) on ForwardA.
  - OpB_next is the same mux on ForwardB.
  - All four encodings are valid; there is no default fall-through.
- Per-edge priority is rst > Flush > Stall > normal load.
- rst:
  - Every output goes to 0, including both counters and Valid_EX.
  - A reset mid-operation discards the EX contents that cycle; no partial state survives.
- Bubble, applied when Flush=1, or Stall=1 with Flush=0:
  - RegWrite_EX, MemRead_EX, MemWrite_EX, RPzero_EX and Valid_EX go to 0.
  - OpA_EX, OpB_EX, Imm_EX, PC_EX, Rd_EX, ALUOp_EX, ALUSrc_EX and WBSel_EX go to 0.
  - A bubble therefore never triggers forwarding or a load-use stall downstream.
- Stall holding ID (PC and IF/ID) is owned upstream. This block only inserts the bubble; the stalled instruction reloads on the first cycle with Stall=0.
- Normal load: all *_ID fields and OpA_next/OpB_next are captured, and Valid_EX becomes 1.
- RPzero_ID passes through unchanged for a live instruction; predicate interpretation is done downstream.
- Counters:
  - StallCount increments when Stall=1 && Flush=0.
  - FlushCount increments when Flush=1, regardless of Stall.
  - Both saturate at all-ones with no wrap.
  - Stall and Flush together produce one bubble: FlushCount increments and StallCount does not.
- Consecutive Stall cycles produce one bubble per cycle, and StallCount increments once per cycle.

Test Plan:
- Reset: hold rst=1 for 2 cycles with nonzero inputs -> every output 0 and Valid_EX=0. Release with RegA_ID=0x11, ForwardA=00, RegWrite_ID=1 -> next edge OpA_EX=0x11, RegWrite_EX=1, Valid_EX=1.
- Forwarding: RegA_ID=0x1, ALUResult_EX=0x2, Result_MEM=0x3, Result_WB=0x4; sweep ForwardA 00/01/10/11 on successive cycles -> OpA_EX=1,2,3,4. Repeat on ForwardB/OpB_EX with ForwardA held at 00 -> no cross-talk.
- Load-use: Stall=1 for 1 cycle with MemRead_ID=1, RegWrite_ID=1, Rd_ID=5 -> EX all control 0, Rd_EX=0, Valid_EX=0, StallCount=1. Next cycle Stall=0 -> the same instruction loads with Rd_EX=5.
- Flush with Stall: assert Flush=1 and Stall=1 together -> single bubble, FlushCount=1, StallCount unchanged.
- Saturation: CNT_W=4, hold Stall=1 for 20 cycles -> StallCount stops at 15. Then assert rst -> StallCount=0.
- Reset mid-stream: assert rst during a burst of valid loads -> outputs 0 on that edge. First post-reset load behaves as in the reset scenario.
